lieat_ifu_ifetch: RTL and testbench
===================================

LIEAT_IFU_IFETCH -- requirements
Module: lieat_ifu_ifetch

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h8000_0000, meaning the first fetch address after reset.
REQ-002 SHALL have parameter FQ_DEPTH, default 2, meaning the fetch-queue entry count (power of two, >=2).
REQ-003 SHALL have the port: clk  in  1  the single clock.
REQ-004 SHALL have the port: rstn  in  1  reset, asynchronous and active-low.
REQ-005 SHALL have the port: flush_req  in  1  redirect pulse, shared with the icache.
REQ-006 SHALL have the port: flush_pc  in  `XLEN  redirect target.
REQ-007 SHALL have the ports: ifetch_req_valid  out  1; ifetch_req_ready  in  1; ifetch_req_pc  out  `XLEN  fetch request to the icache.
REQ-008 SHALL have the ports: ifetch_rsp_valid  in  1; ifetch_rsp_ready  out  1; ifetch_rsp_inst  in  `XLEN  icache response.
REQ-009 SHALL have the ports: ifu_o_valid  out  1; ifu_o_ready  in  1; ifu_o_pc  out  `XLEN; ifu_o_inst  out  `XLEN  decode-side output.

Function
REQ-010 SHALL use an FSM with states REQ (request presented) and HOLD (queue full, no request), one-hot encoded.
REQ-011 SHALL drive ifetch_req_valid = state REQ & ~flush_req, and ifetch_rsp_ready = state REQ & ~flush_req.
REQ-012 SHALL drive ifetch_req_pc from a pc register, held stable from the first request cycle through the response handshake inclusive; one request is outstanding at most.
REQ-013 SHALL define the response handshake as ifetch_rsp_valid & ifetch_rsp_ready; the request-side handshake SHALL NOT advance the pc.
REQ-014 On a response handshake, the block SHALL push {pc, ifetch_rsp_inst} into the queue and set pc <= pc + 4 next cycle.
REQ-015 pc arithmetic SHALL be `XLEN-bit modulo: 32'hFFFF_FFFC + 4 = 32'h0.
REQ-016 REQ -> HOLD when a handshake occurs and the post-cycle queue count equals FQ_DEPTH; otherwise the FSM SHALL stay in REQ.
REQ-017 HOLD -> REQ when the post-cycle queue count < FQ_DEPTH (a pop frees an entry); thus REQ is only entered with a free slot, and a REQ-state push never overflows.
REQ-018 On an icache hit (same-cycle response), throughput SHALL be one instruction per cycle while the queue drains at the same rate.
REQ-019 ifu_o_valid = queue non-empty; ifu_o_pc/ifu_o_inst = head entry, registered (push in cycle N is visible at ifu_o in cycle N+1); pop on ifu_o_valid & ifu_o_ready.
REQ-020 Simultaneous push and pop SHALL keep the count unchanged; pointers SHALL wrap modulo FQ_DEPTH.
REQ-021 On flush_req, next cycle: queue empty, pc = {flush_pc[`XLEN-1:2], 2'b00}, state REQ; any response presented in the flush cycle SHALL be dropped (not pushed).
REQ-022 Flush SHALL take priority over push, pop and every FSM transition in the same cycle.
REQ-023 Once a request is presented, ifetch_req_valid SHALL NOT be withdrawn before its response, except by flush_req.
REQ-024 ifu_o_pc[1:0] SHALL always be 2'b00.

Reset
REQ-025 The block SHALL use an async active-low reset via rstn: state REQ, pc = RESET_PC, queue empty.
REQ-026 During reset, outputs SHALL be: ifetch_req_valid = 0, ifetch_rsp_ready = 0, ifu_o_valid = 0, ifetch_req_pc = RESET_PC, ifu_o_pc = 0, ifu_o_inst = 0.
REQ-027 The first request SHALL be presented in the first cycle after rstn deasserts.

Structure
REQ-028 `XLEN SHALL come from the shared defines file; the state encodings SHALL be localparams.
REQ-029 The queue SHALL be the sub-module lieat_ifu_fetchq (push/pop, count, flush clear); state and pc SHALL use lieat_general_dffrd.

Verification
REQ-030 Reset then hit every cycle, ifu_o_ready = 1 -> ifu_o_pc sequence 0x8000_0000, 0x8000_0004, ... one per cycle, starting the cycle after the first handshake.
REQ-031 Miss with response after 5 cycles -> ifetch_req_pc held at 0x8000_0000 for all 6 cycles, and one push occurs.
REQ-032 ifu_o_ready = 0, hits -> two pushes, then HOLD with ifetch_req_valid = 0; raise ifu_o_ready for one cycle -> REQ next cycle with pc 0x8000_0008.
REQ-033 flush_req with flush_pc 0x1003 while rsp_valid = 1 and queue holds 2 -> response dropped, ifu_o_valid = 0, next ifetch_req_pc = 0x1000.
REQ-034 Flush to 0xFFFF_FFFC, hit -> next pc 0x0000_0000.
REQ-035 Assert rstn mid-miss -> all outputs take the REQ-026 values immediately; the first post-reset request is at RESET_PC.

Source files
------------

// File: rtl/lieat_ifu_ifetch_pkg.sv
// lieat_ifu_ifetch_pkg: shared XLEN define, FSM one-hot encodings, fetch-queue entry type and pc alignment helper
`ifndef XLEN
`define XLEN 32
`endif
package lieat_ifu_ifetch_pkg;
  localparam int XLEN = `XLEN;
  localparam logic [1:0] ST_REQ  = 2'b01;
  localparam logic [1:0] ST_HOLD = 2'b10;
  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] inst;
  } fq_entry_t;
  function automatic logic [XLEN-1:0] pc_align(input logic [XLEN-1:0] a);
    return {a[XLEN-1:2], 2'b00};
  endfunction
endpackage

// File: rtl/lieat_general_dffrd.sv
// lieat_general_dffrd: load-enabled register, async active-low reset to RST_VAL; ports clk, rstn, lden, dnxt -> qout
module lieat_general_dffrd #(
  parameter int DW = 32,
  parameter logic [DW-1:0] RST_VAL = '0
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          lden,
  input  logic [DW-1:0] dnxt,
  output logic [DW-1:0] qout
);
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) qout <= RST_VAL;
    else if (lden) qout <= dnxt;
endmodule

// File: rtl/lieat_ifu_fetchq.sv
// lieat_ifu_fetchq: circular fetch queue; ports clk, rstn, flush (clears), push/wdata, pop -> valid, rdata (head), count
module lieat_ifu_fetchq #(
  parameter int DW    = 64,
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     flush,
  input  logic                     push,
  input  logic [DW-1:0]            wdata,
  input  logic                     pop,
  output logic                     valid,
  output logic [DW-1:0]            rdata,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wptr, rptr;
  // entries are reset so an empty queue presents zeros at the head
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      mem   <= '{default: '0};
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else if (flush) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push) begin
        mem[wptr] <= wdata;
        wptr      <= wptr + 1'b1;
      end
      if (pop) rptr <= rptr + 1'b1;
      count <= count + (AW+1)'(push) - (AW+1)'(pop);
    end
  assign valid = count != '0;
  assign rdata = mem[rptr];
endmodule

// File: rtl/lieat_ifu_ifetch.sv
// lieat_ifu_ifetch: instruction fetch unit; clk/rstn, flush_req/flush_pc redirect, ifetch_req_* and ifetch_rsp_* icache side, ifu_o_* decode side
`ifndef XLEN
`define XLEN 32
`endif
module lieat_ifu_ifetch
  import lieat_ifu_ifetch_pkg::*;
#(
  parameter logic [`XLEN-1:0] RESET_PC = 32'h8000_0000,
  parameter int               FQ_DEPTH = 2
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             flush_req,
  input  logic [`XLEN-1:0] flush_pc,
  output logic             ifetch_req_valid,
  input  logic             ifetch_req_ready,
  output logic [`XLEN-1:0] ifetch_req_pc,
  input  logic             ifetch_rsp_valid,
  output logic             ifetch_rsp_ready,
  input  logic [`XLEN-1:0] ifetch_rsp_inst,
  output logic             ifu_o_valid,
  input  logic             ifu_o_ready,
  output logic [`XLEN-1:0] ifu_o_pc,
  output logic [`XLEN-1:0] ifu_o_inst
);
  localparam int CW = $clog2(FQ_DEPTH) + 1;
  logic [1:0]       state, state_nxt;
  logic [`XLEN-1:0] pc;
  logic [CW-1:0]    cnt, cnt_nxt;
  logic             in_req, push, pop, unused_req_ready;
  fq_entry_t        head;
  // the pc only advances on the response; request acceptance carries no information here
  assign unused_req_ready = ifetch_req_ready;
  // rstn gating keeps the request low while reset is held even though state resets to REQ
  assign in_req           = (state == ST_REQ) & ~flush_req & rstn;
  assign ifetch_req_valid = in_req;
  assign ifetch_rsp_ready = in_req;
  assign ifetch_req_pc    = pc;
  assign push             = ifetch_rsp_valid & ifetch_rsp_ready;
  assign pop              = ifu_o_valid & ifu_o_ready;
  assign cnt_nxt          = cnt + CW'(push) - CW'(pop);
  assign ifu_o_pc         = head.pc;
  assign ifu_o_inst       = head.inst;
  always_comb begin
    state_nxt = state;
    state_nxt = flush_req ? ST_REQ :
                (state == ST_REQ) ? ((push && cnt_nxt == CW'(FQ_DEPTH)) ? ST_HOLD : ST_REQ) :
                (cnt_nxt < CW'(FQ_DEPTH)) ? ST_REQ : ST_HOLD;
  end
  lieat_general_dffrd #(.DW(2), .RST_VAL(ST_REQ)) u_state (
    .clk(clk), .rstn(rstn), .lden(1'b1), .dnxt(state_nxt), .qout(state)
  );
  lieat_general_dffrd #(.DW(`XLEN), .RST_VAL(RESET_PC)) u_pc (
    .clk(clk), .rstn(rstn), .lden(flush_req | push),
    .dnxt(flush_req ? pc_align(flush_pc) : pc + `XLEN'(4)), .qout(pc)
  );
  // flush overrides push/pop inside the queue, so a response in the flush cycle is dropped
  lieat_ifu_fetchq #(.DW($bits(fq_entry_t)), .DEPTH(FQ_DEPTH)) u_fetchq (
    .clk(clk), .rstn(rstn), .flush(flush_req), .push(push),
    .wdata({pc_align(pc), ifetch_rsp_inst}), .pop(pop),
    .valid(ifu_o_valid), .rdata(head), .count(cnt)
  );
endmodule

// File: tb/tb_lieat_ifu_ifetch.sv
// tb_lieat_ifu_ifetch: randomized scoreboard bench for the fetch unit against a queue-based reference model
module tb_lieat_ifu_ifetch;
  localparam logic [31:0] RESET_PC = 32'h8000_0000;
  localparam int D = 2;
  logic        clk = 1'b0, rstn = 1'b0, flush_req = 1'b0;
  logic [31:0] flush_pc = '0, ifetch_req_pc, ifetch_rsp_inst = '0, ifu_o_pc, ifu_o_inst;
  logic        ifetch_req_valid, ifetch_req_ready = 1'b0, ifetch_rsp_valid = 1'b0;
  logic        ifetch_rsp_ready, ifu_o_valid, ifu_o_ready = 1'b0;
  int          tests = 0, fails = 0, mode = 0;
  bit          run = 1'b0;
  logic [63:0] expq[$];
  logic [31:0] mpc;
  logic        exp_req, hs;
  always #5 clk = ~clk;
  lieat_ifu_ifetch #(.RESET_PC(RESET_PC), .FQ_DEPTH(D)) dut (
    .clk(clk), .rstn(rstn), .flush_req(flush_req), .flush_pc(flush_pc),
    .ifetch_req_valid(ifetch_req_valid), .ifetch_req_ready(ifetch_req_ready),
    .ifetch_req_pc(ifetch_req_pc), .ifetch_rsp_valid(ifetch_rsp_valid),
    .ifetch_rsp_ready(ifetch_rsp_ready), .ifetch_rsp_inst(ifetch_rsp_inst),
    .ifu_o_valid(ifu_o_valid), .ifu_o_ready(ifu_o_ready),
    .ifu_o_pc(ifu_o_pc), .ifu_o_inst(ifu_o_inst)
  );
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask
  task automatic chk_reset();
    chk("rst_req_valid", 64'(ifetch_req_valid), 64'(0));
    chk("rst_rsp_ready", 64'(ifetch_rsp_ready), 64'(0));
    chk("rst_o_valid", 64'(ifu_o_valid), 64'(0));
    chk("rst_req_pc", 64'(ifetch_req_pc), 64'(RESET_PC));
    chk("rst_o_pc", 64'(ifu_o_pc), 64'(0));
    chk("rst_o_inst", 64'(ifu_o_inst), 64'(0));
  endtask
  // driver + model: a request is expected whenever the queue has room and no flush;
  // a response handshake queues {pc, inst} and advances the pc by 4 (32-bit wrap)
  initial forever begin
    @(negedge clk);
    if (run) begin
      flush_req        = (mode == 0) && ($urandom_range(0, 19) == 0);
      flush_pc         = ($urandom_range(0, 5) == 0) ? 32'hFFFF_FFFF : $urandom;
      ifetch_rsp_valid = (mode == 1) ? 1'b1 : ($urandom_range(0, 2) != 0);
      ifetch_rsp_inst  = $urandom;
      ifetch_req_ready = 1'($urandom_range(0, 1));
      ifu_o_ready      = (mode == 1) ? 1'b1 : (mode == 2) ? 1'b0 : 1'($urandom_range(0, 1));
      #1;
      exp_req = !flush_req && expq.size() < D;
      chk("req_valid", 64'(ifetch_req_valid), 64'(exp_req));
      chk("rsp_ready", 64'(ifetch_rsp_ready), 64'(exp_req));
      if (exp_req) chk("req_pc", 64'(ifetch_req_pc), 64'(mpc));
      hs = exp_req && ifetch_rsp_valid;
      #2;
      if (flush_req) begin
        expq.delete();
        mpc = flush_pc & ~32'h3;
      end else if (hs) begin
        expq.push_back({mpc, ifetch_rsp_inst});
        mpc = mpc + 32'd4;
      end
    end
  end
  // monitor: compares the presented head with the oldest expected entry
  initial forever begin
    @(negedge clk);
    #2;
    if (run) begin
      chk("o_valid", 64'(ifu_o_valid), 64'(expq.size() != 0));
      if (ifu_o_valid && expq.size() != 0) begin
        chk("o_pc", 64'(ifu_o_pc), 64'(expq[0][63:32]));
        chk("o_inst", 64'(ifu_o_inst), 64'(expq[0][31:0]));
        if (ifu_o_ready && !flush_req) void'(expq.pop_front());
      end
    end
  end
  initial begin
    repeat (3) @(posedge clk);
    #2;
    chk_reset();
    mpc  = RESET_PC;
    rstn = 1'b1;
    run  = 1'b1;
    mode = 1;
    repeat (30) @(posedge clk);
    mode = 2;
    repeat (10) @(posedge clk);
    mode = 0;
    repeat (3000) @(posedge clk);
    #1;
    run = 1'b0;
    #2;
    rstn = 1'b0;
    #1;
    chk_reset();
    expq.delete();
    mpc              = RESET_PC;
    flush_req        = 1'b0;
    ifetch_rsp_valid = 1'b0;
    ifu_o_ready      = 1'b0;
    @(posedge clk);
    #2;
    rstn = 1'b1;
    run  = 1'b1;
    mode = 1;
    repeat (20) @(posedge clk);
    mode = 0;
    repeat (2000) @(posedge clk);
    mode = 2;
    repeat (10) @(posedge clk);
    mode = 0;
    repeat (500) @(posedge clk);
    #1;
    run = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
